ex_mem_stage: RTL and testbench

- Pipeline register and branch-resolution stage directly downstream of the execute ALU.
- Captures the ALU result and zero flag along with the instruction's control bits.
- Resolves BEQ/BNE (the ALU zero flag means "branch condition true") into a registered redirect.
- Pre-formats store data and byte strobes for the memory stage, with a valid/ready handshake on both sides.

---
 rtl/ex_mem_stage.sv | 126 ++++++++++++
 tb/tb_ex_mem_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with branch resolution and
// store pre-formatting. A single skid-less register slot is used, with a
// valid/ready handshake on both sides. Taken branches produce a registered
// one-cycle redirect pulse that does not wait for the memory stage.
module ex_mem_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  // upstream (EX) side
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  alu_zero,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [XLEN-1:0]       pc,
  input  logic [XLEN-1:0]       imm,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  is_branch,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_byte,
  input  logic                  reg_write,
  input  logic                  flush,
  // downstream (MEM) side
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [XLEN-1:0]       mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [3:0]            mem_wstrb,
  output logic [REG_ADDR_W-1:0] mem_rd_o,
  output logic                  mem_rd_en,
  output logic                  mem_regwr,
  output logic                  misalign,
  // front-end redirect
  output logic                  redirect,
  output logic [XLEN-1:0]       redirect_pc
);

  // Everything that moves together into the register slot on accept.
  typedef struct packed {
    logic [XLEN-1:0]       addr;
    logic [XLEN-1:0]       wdata;
    logic [3:0]            wstrb;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_en;
    logic                  regwr;
    logic                  mis;
    logic [XLEN-1:0]       tgt;
  } payload_t;

  payload_t nxt;
  payload_t cur;
  logic     accept;
  logic     taken;
  logic     word_acc;
  logic     mis_in;
  logic     mem_op;

  // The slot frees up when empty or when its occupant leaves this cycle.
  assign ex_ready = !mem_valid | mem_ready;

  // A flush kills anything arriving in the same cycle.
  assign accept = ex_valid & ex_ready & !flush;

  // Branch condition is computed by the ALU; zero flag means "condition true".
  assign taken = is_branch & alu_zero;

  // Word accesses must be naturally aligned; byte accesses never trap.
  assign word_acc = (mem_read | mem_write) & !mem_byte;
  assign mis_in   = word_acc & (alu_result[1:0] != 2'b00);
  assign mem_op   = !is_branch & !mis_in;

  // Pre-format the incoming instruction into its registered form.
  always_comb begin
    nxt       = '0;
    nxt.addr  = alu_result;
    nxt.rd    = rd;
    nxt.mis   = mis_in;
    nxt.tgt   = pc + imm;
    // byte stores drive the byte on every lane so the strobe picks the lane
    nxt.wdata = mem_byte ? {4{rs2_data[7:0]}} : rs2_data;
    nxt.wstrb = 4'b0000;
    if (mem_write && mem_op) begin
      nxt.wstrb = mem_byte ? (4'b0001 << alu_result[1:0]) : 4'b1111;
    end
    nxt.rd_en = mem_read & mem_op;
    // x0 is hardwired, so a write to it is dropped here rather than later
    nxt.regwr = reg_write & mem_op & (rd != '0);
  end

  // Slot occupancy and the one-cycle redirect pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid <= 1'b0;
      redirect  <= 1'b0;
    end else if (flush) begin
      mem_valid <= 1'b0;
      redirect  <= 1'b0;
    end else begin
      if (accept)         mem_valid <= 1'b1;
      else if (mem_ready) mem_valid <= 1'b0;
      redirect <= accept & taken;
    end
  end

  // Payload register: loads only on accept, otherwise holds (stale after flush).
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= '0;
    end else if (accept) begin
      cur <= nxt;
    end
  end

  assign mem_addr    = cur.addr;
  assign mem_wdata   = cur.wdata;
  assign mem_wstrb   = cur.wstrb;
  assign mem_rd_o    = cur.rd;
  assign mem_rd_en   = cur.rd_en;
  assign mem_regwr   = cur.regwr;
  assign misalign    = cur.mis;
  assign redirect_pc = cur.tgt;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage. Expected entries are pushed to a
// scoreboard queue when stimulus is accepted and popped one cycle later.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] rs2_data;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic        is_branch;
  logic        mem_read;
  logic        mem_write;
  logic        mem_byte;
  logic        reg_write;
  logic        flush;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [4:0]  mem_rd_o;
  logic        mem_rd_en;
  logic        mem_regwr;
  logic        misalign;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  ex_mem_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .rs2_data(rs2_data),
    .pc(pc), .imm(imm), .rd(rd),
    .is_branch(is_branch), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte(mem_byte), .reg_write(reg_write), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rd_o(mem_rd_o), .mem_rd_en(mem_rd_en), .mem_regwr(mem_regwr),
    .misalign(misalign), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  rd;
    logic        rd_en;
    logic        regwr;
    logic        mis;
    logic        redir;
    logic [31:0] rpc;
  } obs_t;

  obs_t q[$];
  obs_t e, a;
  int   checks = 0;
  int   failures = 0;

  function automatic obs_t mk(input logic v, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              input logic [4:0] r, input logic rd_en,
                              input logic regwr, input logic mis,
                              input logic redir, input logic [31:0] rpc);
    obs_t o;
    o.v = v; o.addr = addr; o.wdata = wdata; o.wstrb = wstrb; o.rd = r;
    o.rd_en = rd_en; o.regwr = regwr; o.mis = mis; o.redir = redir;
    o.rpc = rpc;
    return o;
  endfunction

  // redirect_pc is only meaningful for taken branches; other entries leave it out
  function automatic obs_t observe(input logic keep_pc);
    obs_t o;
    o.v = mem_valid; o.addr = mem_addr; o.wdata = mem_wdata;
    o.wstrb = mem_wstrb; o.rd = mem_rd_o; o.rd_en = mem_rd_en;
    o.regwr = mem_regwr; o.mis = misalign; o.redir = redirect;
    o.rpc = keep_pc ? redirect_pc : 32'h0;
    return o;
  endfunction

  task automatic set_in(input logic v, input logic [31:0] res, input logic z,
                        input logic [31:0] rs2, input logic [31:0] p,
                        input logic [31:0] im, input logic [4:0] r,
                        input logic br, input logic rdm, input logic wrm,
                        input logic bm, input logic rw);
    ex_valid = v; alu_result = res; alu_zero = z; rs2_data = rs2; pc = p;
    imm = im; rd = r; is_branch = br; mem_read = rdm; mem_write = wrm;
    mem_byte = bm; reg_write = rw;
  endtask

  task automatic clr_in();
    set_in(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; mem_ready = 1'b0;
    set_in(1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'h100, 32'h4, 5'd7,
           1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk); @(negedge clk);
    a = observe(1'b1);
    checks++;
    if (a !== '0) begin
      failures++; $display("FAIL reset_state got=%h exp=0", a);
    end
    checks++;
    if (ex_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b exp=1", ex_ready);
    end
    reset = 1'b0; mem_ready = 1'b1; clr_in();
    @(negedge clk);
  endtask

  task automatic test_alu();
    set_in(1'b1, 32'h10, 1'b0, 32'h55, 32'h200, 32'h4, 5'd3, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (ex_ready !== 1'b1) begin
      failures++; $display("FAIL alu_ready got=%b exp=1", ex_ready);
    end
    q.push_back(mk(1, 32'h10, 32'h55, 4'h0, 5'd3, 0, 1, 0, 0, 32'h0));
    @(negedge clk);
    e = q.pop_front(); a = observe(e.redir);
    checks++;
    if (a !== e) begin
      failures++; $display("FAIL alu_add got=%h exp=%h", a, e);
    end
    // write to x0 must not request a register write
    set_in(1'b1, 32'h20, 1'b0, 32'h66, 32'h204, 32'h4, 5'd0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b1);
    q.push_back(mk(1, 32'h20, 32'h66, 4'h0, 5'd0, 0, 0, 0, 0, 32'h0));
    @(negedge clk);
    e = q.pop_front(); a = observe(e.redir);
    checks++;
    if (a !== e) begin
      failures++; $display("FAIL alu_rd0 got=%h exp=%h", a, e);
    end
    clr_in();
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0) begin
      failures++; $display("FAIL alu_drain got=%b exp=0", mem_valid);
    end
  endtask

  task automatic test_branch();
    set_in(1'b1, 32'h0, 1'b1, 32'h0, 32'h100, 32'hFFFF_FFF0, 5'd9, 1'b1,
           1'b0, 1'b0, 1'b0, 1'b1);
    q.push_back(mk(1, 32'h0, 32'h0, 4'h0, 5'd9, 0, 0, 0, 1, 32'hF0));
    @(negedge clk);
    e = q.pop_front(); a = observe(e.redir);
    checks++;
    if (a !== e) begin
      failures++; $display("FAIL beq_taken got=%h exp=%h", a, e);
    end
    clr_in();
    @(negedge clk);
    checks++;
    if (redirect !== 1'b0) begin
      failures++; $display("FAIL redirect_pulse got=%b exp=0", redirect);
    end
    set_in(1'b1, 32'h0, 1'b0, 32'h0, 32'h100, 32'hFFFF_FFF0, 5'd9, 1'b1,
           1'b0, 1'b0, 1'b0, 1'b1);
    q.push_back(mk(1, 32'h0, 32'h0, 4'h0, 5'd9, 0, 0, 0, 0, 32'h0));
    @(negedge clk);
    e = q.pop_front(); a = observe(e.redir);
    checks++;
    if (a !== e) begin
      failures++; $display("FAIL beq_not_taken got=%h exp=%h", a, e);
    end
    clr_in();
    @(negedge clk);
  endtask

  // Memory ops issued back to back with mem_ready high: one per cycle, no bubble.
  task automatic test_store();
    logic [31:0] res [7];
    logic [31:0] rs2 [7];
    logic [4:0]  rds [7];
    logic [3:0]  ctl [7];   // {mem_read, mem_write, mem_byte, reg_write}
    obs_t        ex  [7];
    res = '{32'h2003, 32'h2002, 32'h2001, 32'h2004, 32'h2000, 32'h2002, 32'h2008};
    rs2 = '{32'h1234_56AB, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h77, 32'h0,
            32'hCAFE_F00D};
    rds = '{5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 5'd5, 5'd0};
    ctl = '{4'b0110, 4'b0100, 4'b1001, 4'b1001, 4'b0110, 4'b1011, 4'b0100};
    ex  = '{mk(1, 32'h2003, 32'hABAB_ABAB, 4'b1000, 5'd0, 0, 0, 0, 0, 0),
            mk(1, 32'h2002, 32'hDEAD_BEEF, 4'b0000, 5'd0, 0, 0, 1, 0, 0),
            mk(1, 32'h2001, 32'h0,         4'b0000, 5'd4, 0, 0, 1, 0, 0),
            mk(1, 32'h2004, 32'h0,         4'b0000, 5'd4, 1, 1, 0, 0, 0),
            mk(1, 32'h2000, 32'h7777_7777, 4'b0001, 5'd0, 0, 0, 0, 0, 0),
            mk(1, 32'h2002, 32'h0,         4'b0000, 5'd5, 1, 1, 0, 0, 0),
            mk(1, 32'h2008, 32'hCAFE_F00D, 4'b1111, 5'd0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, res[i], 1'b0, rs2[i], 32'h0, 32'h0, rds[i], 1'b0,
             ctl[i][3], ctl[i][2], ctl[i][1], ctl[i][0]);
      #1;
      checks++;
      if (ex_ready !== 1'b1) begin
        failures++; $display("FAIL mem_b2b_ready idx=%0d got=%b exp=1", i, ex_ready);
      end
      q.push_back(ex[i]);
      @(negedge clk);
      e = q.pop_front(); a = observe(e.redir);
      checks++;
      if (a !== e) begin
        failures++; $display("FAIL mem_op idx=%0d got=%h exp=%h", i, a, e);
      end
    end
    clr_in();
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    set_in(1'b1, 32'hA0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd1, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b1);
    q.push_back(mk(1, 32'hA0, 32'h0, 4'h0, 5'd1, 0, 1, 0, 0, 32'h0));
    @(negedge clk);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      // the waiting instruction keeps changing; none of it may leak in
      set_in(1'b1, 32'hB0 + 32'(k * 4), 1'b0, 32'h0, 32'h0, 32'h0, 5'd2,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1;
      checks++;
      if (ex_ready !== 1'b0) begin
        failures++; $display("FAIL bp_ready_low cyc=%0d got=%b exp=0", k, ex_ready);
      end
      e = q[0]; a = observe(e.redir);
      checks++;
      if (a !== e) begin
        failures++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", k, a, e);
      end
      @(negedge clk);
    end
    e = q[0]; a = observe(e.redir);
    checks++;
    if (a !== e) begin
      failures++; $display("FAIL bp_hold_last got=%h exp=%h", a, e);
    end
    set_in(1'b1, 32'hB0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b1);
    mem_ready = 1'b1;
    #1;
    checks++;
    if (ex_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release_ready got=%b exp=1", ex_ready);
    end
    void'(q.pop_front());  // old entry drains on this edge
    q.push_back(mk(1, 32'hB0, 32'h0, 4'h0, 5'd2, 0, 1, 0, 0, 32'h0));
    @(negedge clk);
    e = q.pop_front(); a = observe(e.redir);
    checks++;
    if (a !== e) begin
      failures++; $display("FAIL bp_no_bubble got=%h exp=%h", a, e);
    end
    clr_in();
    @(negedge clk);
  endtask

  task automatic test_flush();
    set_in(1'b1, 32'hC0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd6, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b1);
    @(negedge clk);
    mem_ready = 1'b0;
    set_in(1'b1, 32'hD0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'hC0) begin
      failures++; $display("FAIL flush_pre got=%b/%h exp=1/000000c0", mem_valid, mem_addr);
    end
    // flush with a taken branch arriving and the slot nominally free
    flush = 1'b1; mem_ready = 1'b1;
    set_in(1'b1, 32'h0, 1'b1, 32'h0, 32'h300, 32'h10, 5'd0, 1'b1, 1'b0,
           1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0 || redirect !== 1'b0) begin
      failures++; $display("FAIL flush_kill got=%b/%b exp=0/0", mem_valid, redirect);
    end
    flush = 1'b0; clr_in();
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b0 || redirect !== 1'b0) begin
      failures++; $display("FAIL flush_no_ghost got=%b/%b exp=0/0", mem_valid, redirect);
    end
  endtask

  task automatic test_reset_hold();
    set_in(1'b1, 32'h3000, 1'b0, 32'h1122_3344, 32'h0, 32'h0, 5'd0, 1'b0,
           1'b0, 1'b1, 1'b0, 1'b0);
    q.push_back(mk(1, 32'h3000, 32'h1122_3344, 4'b1111, 5'd0, 0, 0, 0, 0, 0));
    @(negedge clk);
    e = q.pop_front(); a = observe(e.redir);
    checks++;
    if (a !== e) begin
      failures++; $display("FAIL rh_pre got=%h exp=%h", a, e);
    end
    mem_ready = 1'b0; clr_in();
    @(negedge clk);
    reset = 1'b1;
    set_in(1'b1, 32'h0, 1'b1, 32'h0, 32'h400, 32'h20, 5'd0, 1'b1, 1'b0,
           1'b0, 1'b0, 1'b0);
    @(negedge clk);
    a = observe(1'b1);
    checks++;
    if (a !== '0) begin
      failures++; $display("FAIL rh_state got=%h exp=0", a);
    end
    checks++;
    if (ex_ready !== 1'b1) begin
      failures++; $display("FAIL rh_ready got=%b exp=1", ex_ready);
    end
    reset = 1'b0; mem_ready = 1'b1; clr_in();
    @(negedge clk);
    checks++;
    if (redirect !== 1'b0 || mem_valid !== 1'b0) begin
      failures++; $display("FAIL rh_no_redirect got=%b/%b exp=0/0", redirect, mem_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; mem_ready = 1'b1;
    clr_in();
    test_reset();
    test_alu();
    test_branch();
    test_store();
    test_backpressure();
    test_flush();
    test_reset_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
